// File: rtl/ins_exec_alu_seq.sv
// ins_exec_alu_seq: decodes OP / OP-IMM integer instructions and returns a register write-back request.
// Define INS_EXEC_ALU_FAST_SHIFT_EN to replace the bit-serial shifter with a single-cycle barrel shifter.
module ins_exec_alu_seq #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      ins_dec_op,
   input  logic [2:0]      ins_dec_funct3,
   input  logic [6:0]      ins_dec_funct7,
   input  logic [XLEN-1:0] reg_rs1_val,
   input  logic [XLEN-1:0] reg_rs2_val,
   input  logic [XLEN-1:0] imm_ext_ext,
   input  logic [4:0]      reg_rd,
   output logic            out_valid,
   output logic            reg_w_op,
   output logic [4:0]      reg_w_reg_idx,
   output logic [XLEN-1:0] reg_w_reg_val
);

   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] SEL_BASE = 7'h00;
   localparam logic [6:0] SEL_ALT  = 7'h20;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_XOR,
      ALU_OR,
      ALU_AND,
      ALU_SLT,
      ALU_SLTU,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA
   } alu_e;

   state_e          state_q, state_d;
   alu_e            dec_alu, alu_q;
   logic            is_imm, is_reg, sel_base, sel_alt;
   logic            dec_legal, dec_shift, take;
   logic [6:0]      dec_sel;
   logic [XLEN-1:0] dec_op2;
   logic [SHW-1:0]  dec_shamt;
   logic [XLEN-1:0] op1_q, op2_q, acc_q;
   logic [XLEN-1:0] acc_load, acc_step, result;
   logic [SHW-1:0]  cnt_q, cnt_dec;
   logic [4:0]      rd_q;
   logic            legal_q;

   assign take    = in_valid && in_ready;
   assign cnt_dec = cnt_q - SHW'(1);

   // For RV64 immediate shifts imm[5] belongs to the shift amount, so it is masked out of the selector.
   always_comb begin
      is_imm    = (ins_dec_op == OP_IMM);
      is_reg    = (ins_dec_op == OP_REG);
      dec_op2   = is_imm ? imm_ext_ext : reg_rs2_val;
      dec_shamt = dec_op2[SHW-1:0];
      if (is_reg) begin
         dec_sel = ins_dec_funct7;
      end else if (XLEN == 64) begin
         dec_sel = {imm_ext_ext[11:6], 1'b0};
      end else begin
         dec_sel = imm_ext_ext[11:5];
      end
      sel_base  = (dec_sel == SEL_BASE);
      sel_alt   = (dec_sel == SEL_ALT);
      dec_alu   = ALU_ADD;
      dec_legal = is_imm || is_reg;
      case (ins_dec_funct3)
         3'b000: begin
            dec_alu = (is_reg && sel_alt) ? ALU_SUB : ALU_ADD;
            if (is_reg && !sel_base && !sel_alt) dec_legal = 1'b0;
         end
         3'b001: begin
            dec_alu = ALU_SLL;
            if (!sel_base) dec_legal = 1'b0;
         end
         3'b101: begin
            dec_alu = sel_alt ? ALU_SRA : ALU_SRL;
            if (!sel_base && !sel_alt) dec_legal = 1'b0;
         end
         3'b010: begin
            dec_alu = ALU_SLT;
            if (is_reg && !sel_base) dec_legal = 1'b0;
         end
         3'b011: begin
            dec_alu = ALU_SLTU;
            if (is_reg && !sel_base) dec_legal = 1'b0;
         end
         3'b100: begin
            dec_alu = ALU_XOR;
            if (is_reg && !sel_base) dec_legal = 1'b0;
         end
         3'b110: begin
            dec_alu = ALU_OR;
            if (is_reg && !sel_base) dec_legal = 1'b0;
         end
         default: begin
            dec_alu = ALU_AND;
            if (is_reg && !sel_base) dec_legal = 1'b0;
         end
      endcase
      dec_shift = dec_legal && (dec_alu inside {ALU_SLL, ALU_SRL, ALU_SRA});
   end

`ifdef INS_EXEC_ALU_FAST_SHIFT_EN
   // The accumulator receives the fully shifted value at transfer, so no SHIFT cycles are needed.
   always_comb begin
      acc_step = acc_q;
      case (dec_alu)
         ALU_SLL: acc_load = reg_rs1_val << dec_shamt;
         ALU_SRA: acc_load = XLEN'($signed(reg_rs1_val) >>> dec_shamt);
         default: acc_load = reg_rs1_val >> dec_shamt;
      endcase
   end
`else
   // SRA refills from the captured sign bit, which stays valid while the accumulator shifts.
   always_comb begin
      acc_load = reg_rs1_val;
      case (alu_q)
         ALU_SLL: acc_step = {acc_q[XLEN-2:0], 1'b0};
         ALU_SRA: acc_step = {op1_q[XLEN-1], acc_q[XLEN-1:1]};
         default: acc_step = {1'b0, acc_q[XLEN-1:1]};
      endcase
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
`ifdef INS_EXEC_ALU_FAST_SHIFT_EN
               state_d = S_DONE;
`else
               state_d = (dec_shift && (dec_shamt != '0)) ? S_SHIFT : S_DONE;
`endif
            end
         end
         S_SHIFT: begin
            if (cnt_dec == '0) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         rd_q    <= '0;
         alu_q   <= ALU_ADD;
         legal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take) begin
            op1_q   <= reg_rs1_val;
            op2_q   <= dec_op2;
            rd_q    <= reg_rd;
            alu_q   <= dec_alu;
            legal_q <= dec_legal;
            acc_q   <= acc_load;
            cnt_q   <= dec_shamt;
         end else if (state_q == S_SHIFT) begin
            acc_q <= acc_step;
            cnt_q <= cnt_dec;
         end
      end
   end

   always_comb begin
      result = '0;
      case (alu_q)
         ALU_ADD:  result = op1_q + op2_q;
         ALU_SUB:  result = op1_q - op2_q;
         ALU_XOR:  result = op1_q ^ op2_q;
         ALU_OR:   result = op1_q | op2_q;
         ALU_AND:  result = op1_q & op2_q;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op1_q) < $signed(op2_q))};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op1_q < op2_q)};
         ALU_SLL, ALU_SRL, ALU_SRA: result = acc_q;
         default:  result = '0;
      endcase
   end

   assign in_ready      = (state_q == S_IDLE);
   assign out_valid     = (state_q == S_DONE);
   assign reg_w_op      = out_valid && legal_q && (rd_q != 5'd0);
   assign reg_w_reg_idx = out_valid ? rd_q : 5'd0;
   assign reg_w_reg_val = (out_valid && legal_q) ? result : '0;

endmodule

// File: tb/tb_ins_exec_alu_seq.sv
// tb_ins_exec_alu_seq: directed vector table, randomized reference-model comparison and reset corner
// cases for a 32-bit and a 64-bit instance of ins_exec_alu_seq.
`timescale 1ns/1ps
module tb_ins_exec_alu_seq;

`ifdef INS_EXEC_ALU_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam logic [6:0] OPI = 7'h13;
   localparam logic [6:0] OPR = 7'h33;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  op, f7;
   logic [2:0]  f3;
   logic [63:0] rs1, rs2, imm;
   logic [4:0]  rd;
   logic        valid32, ready32, ov32, wop32;
   logic [4:0]  idx32;
   logic [31:0] val32;
   logic        valid64, ready64, ov64, wop64;
   logic [4:0]  idx64;
   logic [63:0] val64;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit          w64;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] a, b, imm;
      logic [4:0]  rd;
      logic        wop;
      logic [63:0] val;
      int          lat;
      string       name;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   ins_exec_alu_seq #(.XLEN(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(valid32), .in_ready(ready32),
      .ins_dec_op(op), .ins_dec_funct3(f3), .ins_dec_funct7(f7),
      .reg_rs1_val(rs1[31:0]), .reg_rs2_val(rs2[31:0]), .imm_ext_ext(imm[31:0]), .reg_rd(rd),
      .out_valid(ov32), .reg_w_op(wop32), .reg_w_reg_idx(idx32), .reg_w_reg_val(val32)
   );

   ins_exec_alu_seq #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(valid64), .in_ready(ready64),
      .ins_dec_op(op), .ins_dec_funct3(f3), .ins_dec_funct7(f7),
      .reg_rs1_val(rs1), .reg_rs2_val(rs2), .imm_ext_ext(imm), .reg_rd(rd),
      .out_valid(ov64), .reg_w_op(wop64), .reg_w_reg_idx(idx64), .reg_w_reg_val(val64)
   );

   function automatic logic get_ready(input bit w);
      return w ? ready64 : ready32;
   endfunction
   function automatic logic get_ov(input bit w);
      return w ? ov64 : ov32;
   endfunction
   function automatic logic get_wop(input bit w);
      return w ? wop64 : wop32;
   endfunction
   function automatic logic [4:0] get_idx(input bit w);
      return w ? idx64 : idx32;
   endfunction
   function automatic logic [63:0] get_val(input bit w);
      return w ? val64 : {32'b0, val32};
   endfunction

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   task automatic add_vec(input bit w, input logic [6:0] vop, input logic [2:0] vf3,
                          input logic [6:0] vf7, input logic [63:0] va, input logic [63:0] vb,
                          input logic [63:0] vimm, input logic [4:0] vrd, input logic vwop,
                          input logic [63:0] vval, input int vlat, input string vname);
      vec_t v;
      v.w64 = w; v.op = vop; v.f3 = vf3; v.f7 = vf7; v.a = va; v.b = vb; v.imm = vimm;
      v.rd = vrd; v.wop = vwop; v.val = vval; v.lat = vlat; v.name = vname;
      tbl.push_back(v);
   endtask

   // Reference for a 32-bit instruction, straight from the ISA rules; lat is the bit-serial latency.
   function automatic void model32(input logic [6:0] mop, input logic [2:0] mf3, input logic [6:0] mf7,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                   output bit legal, output logic [31:0] res, output int lat);
      bit itype, rtype, shift_op;
      logic [31:0] y;
      logic [6:0]  sel;
      int sh;
      itype    = (mop == OPI);
      rtype    = (mop == OPR);
      y        = itype ? im : b;
      sel      = itype ? im[11:5] : mf7;
      sh       = int'(y[4:0]);
      legal    = itype || rtype;
      shift_op = (mf3 == 3'd1) || (mf3 == 3'd5);
      res      = 32'd0;
      case (mf3)
         3'd0: begin
            if (rtype && sel == 7'h20) res = a - b;
            else begin
               res = a + y;
               if (rtype && sel != 7'h00) legal = 1'b0;
            end
         end
         3'd1: begin
            res = a << sh;
            if (sel != 7'h00) legal = 1'b0;
         end
         3'd5: begin
            if (sel == 7'h20) res = 32'($signed(a) >>> sh);
            else begin
               res = a >> sh;
               if (sel != 7'h00) legal = 1'b0;
            end
         end
         default: begin
            case (mf3)
               3'd2:    res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
               3'd3:    res = (a < y) ? 32'd1 : 32'd0;
               3'd4:    res = a ^ y;
               3'd6:    res = a | y;
               default: res = a & y;
            endcase
            if (rtype && sel != 7'h00) legal = 1'b0;
         end
      endcase
      if (!legal) res = 32'd0;
      lat = (legal && shift_op) ? 2 + sh : 2;
   endfunction

   function automatic logic [6:0] pick_sel();
      case ($urandom_range(0, 3))
         0, 1:    return 7'h00;
         2:       return 7'h20;
         default: return 7'($urandom);
      endcase
   endfunction

   // Presents one instruction, scrambles the inputs after transfer and checks the single result pulse.
   task automatic apply_stimulus(input bit w, input logic [6:0] vop, input logic [2:0] vf3,
                                 input logic [6:0] vf7, input logic [63:0] va, input logic [63:0] vb,
                                 input logic [63:0] vimm, input logic [4:0] vrd, input logic exp_wop,
                                 input logic [63:0] exp_val, input int lat_iter, input string name);
      int edges;
      int busy_bad;
      int exp_lat;
      exp_lat = FAST ? 2 : lat_iter;
      @(negedge clk);
      check_output({name, " ready_idle"}, 64'(get_ready(w)), 64'd1);
      op = vop; f3 = vf3; f7 = vf7; rs1 = va; rs2 = vb; imm = vimm; rd = vrd;
      if (w) valid64 = 1'b1;
      else valid32 = 1'b1;
      @(negedge clk);
      valid32 = 1'b0;
      valid64 = 1'b0;
      op  = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom); rd = 5'($urandom);
      rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom}; imm = {$urandom, $urandom};
      edges    = 1;
      busy_bad = 0;
      while (!get_ov(w) && edges < 100) begin
         if (get_ready(w)) busy_bad++;
         @(negedge clk);
         edges++;
      end
      check_output({name, " latency"}, 64'(edges + 1), 64'(exp_lat));
      check_output({name, " busy_ready"}, 64'(busy_bad), 64'd0);
      check_output({name, " wop"}, 64'(get_wop(w)), 64'(exp_wop));
      check_output({name, " idx"}, 64'(get_idx(w)), 64'(vrd));
      check_output({name, " val"}, get_val(w), exp_val);
      check_output({name, " ready_done"}, 64'(get_ready(w)), 64'd0);
      @(negedge clk);
      check_output({name, " pulse_end"}, 64'(get_ov(w)), 64'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      check_output({name, " ready32"}, 64'(ready32), 64'd1);
      check_output({name, " ov32"}, 64'(ov32), 64'd0);
      check_output({name, " wop32"}, 64'(wop32), 64'd0);
      check_output({name, " idx32"}, 64'(idx32), 64'd0);
      check_output({name, " val32"}, 64'(val32), 64'd0);
      check_output({name, " ready64"}, 64'(ready64), 64'd1);
      check_output({name, " ov64"}, 64'(ov64), 64'd0);
   endtask

   initial begin
      logic [6:0]  rop, rf7, hi;
      logic [2:0]  rf3;
      logic [31:0] ra, rb, rimm, rres;
      logic [11:0] i12;
      logic [4:0]  rrd;
      bit          lg;
      int          rlat, pulses;

      rst_n = 1'b0; valid32 = 1'b0; valid64 = 1'b0;
      op = '0; f3 = '0; f7 = '0; rs1 = '0; rs2 = '0; imm = '0; rd = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      add_vec(0, OPI, 3'd0, 7'h55, 64'hFFFFFFFF, 64'h0, 64'h1, 5'd5, 1'b1, 64'h0, 2, "addi_wrap");
      add_vec(0, OPI, 3'd5, 7'h00, 64'h80000000, 64'h0, 64'h41F, 5'd3, 1'b1, 64'hFFFFFFFF, 33, "srai_31");
      add_vec(0, OPR, 3'd3, 7'h00, 64'h1, 64'hFFFFFFFF, 64'h0, 5'd0, 1'b0, 64'h1, 2, "sltu_x0");
      add_vec(0, OPI, 3'd1, 7'h00, 64'h12345678, 64'h0, 64'h020, 5'd7, 1'b0, 64'h0, 2, "slli_shamt5");
      add_vec(0, OPR, 3'd0, 7'h20, 64'h5, 64'h7, 64'h0, 5'd1, 1'b1, 64'hFFFFFFFE, 2, "sub_neg");
      add_vec(0, OPR, 3'd2, 7'h00, 64'hFFFFFFFF, 64'h1, 64'h0, 5'd2, 1'b1, 64'h1, 2, "slt_signed");
      add_vec(0, OPR, 3'd3, 7'h00, 64'hFFFFFFFF, 64'h1, 64'h0, 5'd2, 1'b1, 64'h0, 2, "sltu_big");
      add_vec(0, OPI, 3'd4, 7'h7F, 64'h0F0F0F0F, 64'h0, 64'hFFFFFFFF, 5'd8, 1'b1, 64'hF0F0F0F0, 2, "xori_neg");
      add_vec(0, OPI, 3'd6, 7'h00, 64'h12340000, 64'h0, 64'h567, 5'd9, 1'b1, 64'h12340567, 2, "ori");
      add_vec(0, OPR, 3'd7, 7'h00, 64'hFF00FF00, 64'h0FF00FF0, 64'h0, 5'd10, 1'b1, 64'h0F000F00, 2, "and");
      add_vec(0, OPR, 3'd5, 7'h00, 64'h80000000, 64'h4, 64'h0, 5'd11, 1'b1, 64'h08000000, 6, "srl_4");
      add_vec(0, OPR, 3'd1, 7'h00, 64'h1, 64'hFFFFFFE0, 64'h0, 5'd12, 1'b1, 64'h1, 2, "sll_zero");
      add_vec(0, OPR, 3'd1, 7'h00, 64'h80000001, 64'h1, 64'h0, 5'd13, 1'b1, 64'h2, 3, "sll_1");
      add_vec(0, OPR, 3'd0, 7'h01, 64'h3, 64'h4, 64'h0, 5'd14, 1'b0, 64'h0, 2, "add_bad_f7");
      add_vec(0, OPR, 3'd4, 7'h20, 64'h3, 64'h4, 64'h0, 5'd15, 1'b0, 64'h0, 2, "xor_alt_f7");
      add_vec(0, 7'h03, 3'd0, 7'h00, 64'h3, 64'h4, 64'h4, 5'd16, 1'b0, 64'h0, 2, "bad_opcode");
      add_vec(0, OPR, 3'd5, 7'h20, 64'h7FFFFFF0, 64'h4, 64'h0, 5'd17, 1'b1, 64'h07FFFFFF, 6, "sra_pos");
      add_vec(0, OPI, 3'd5, 7'h00, 64'hF0000000, 64'h0, 64'h404, 5'd18, 1'b1, 64'hFF000000, 6, "srai_neg");
      add_vec(0, OPR, 3'd0, 7'h00, 64'h7FFFFFFF, 64'h1, 64'h0, 5'd19, 1'b1, 64'h80000000, 2, "add_ovf");
      add_vec(0, OPI, 3'd2, 7'h00, 64'h5, 64'h0, 64'hFFFFFFFF, 5'd20, 1'b1, 64'h0, 2, "slti_neg");
      add_vec(0, OPI, 3'd3, 7'h00, 64'h5, 64'h0, 64'hFFFFFFFF, 5'd21, 1'b1, 64'h1, 2, "sltiu_max");
      add_vec(0, OPI, 3'd5, 7'h00, 64'h80000000, 64'h0, 64'h1F, 5'd22, 1'b1, 64'h1, 33, "srli_31");
      add_vec(0, OPI, 3'd1, 7'h00, 64'h1, 64'h0, 64'h1F, 5'd23, 1'b1, 64'h80000000, 33, "slli_31");
      add_vec(1, OPR, 3'd5, 7'h00, 64'h8000000000000000, 64'd63, 64'h0, 5'd6, 1'b1, 64'h1, 65, "srl64_63");
      add_vec(1, OPI, 3'd1, 7'h00, 64'h1, 64'h0, 64'h020, 5'd7, 1'b1, 64'h100000000, 34, "slli64_32");
      add_vec(1, OPI, 3'd5, 7'h00, 64'h8000000000000000, 64'h0, 64'h43F, 5'd8, 1'b1,
              64'hFFFFFFFFFFFFFFFF, 65, "srai64_63");
      add_vec(1, OPR, 3'd0, 7'h20, 64'h0, 64'h1, 64'h0, 5'd9, 1'b1, 64'hFFFFFFFFFFFFFFFF, 2, "sub64");

      foreach (tbl[i]) begin
         apply_stimulus(tbl[i].w64, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].a, tbl[i].b, tbl[i].imm,
                        tbl[i].rd, tbl[i].wop, tbl[i].val, tbl[i].lat, tbl[i].name);
      end

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: rop = OPI;
            4, 5, 6, 7: rop = OPR;
            default:    rop = 7'($urandom);
         endcase
         rf3 = 3'($urandom);
         rf7 = pick_sel();
         hi  = pick_sel();
         if ($urandom_range(0, 3) == 0) hi[0] = 1'b1;
         i12  = {hi, 5'($urandom)};
         rimm = {{20{i12[11]}}, i12};
         ra   = $urandom;
         rb   = $urandom;
         rrd  = 5'($urandom);
         model32(rop, rf3, rf7, ra, rb, rimm, lg, rres, rlat);
         apply_stimulus(1'b0, rop, rf3, rf7, {32'b0, ra}, {32'b0, rb}, {32'b0, rimm}, rrd,
                        lg && (rrd != 5'd0), {32'b0, rres}, rlat, $sformatf("rand%0d", i));
      end

      // Reset in the middle of a long shift, then reset held against a pending in_valid.
      @(negedge clk);
      op = OPR; f3 = 3'd1; f7 = 7'h00; rs1 = 64'h1; rs2 = 64'd20; rd = 5'd4; valid32 = 1'b1;
      @(negedge clk);
      valid32 = 1'b0;
      pulses  = 0;
      repeat (8) begin
         if (ov32) pulses++;
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midshift_reset");
      check_output("midshift_no_pulse", 64'(pulses), 64'd0);
      op = OPI; f3 = 3'd0; imm = 64'h1; rd = 5'd5; valid32 = 1'b1;
      @(negedge clk);
      check_output("reset_priority ov", 64'(ov32), 64'd0);
      check_output("reset_priority ready", 64'(ready32), 64'd1);
      valid32 = 1'b0;
      rst_n   = 1'b1;
      pulses  = 0;
      repeat (30) begin
         @(negedge clk);
         if (ov32) pulses++;
      end
      check_output("abandoned_no_pulse", 64'(pulses), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
